serial_mag_compare: RTL and testbench
=====================================

SERIAL_MAG_COMPARE -- requirements
Module: serial_mag_compare

Interface
REQ-001 SHALL have parameter WIDTH, default 6, operand width in bits (legal range 2..32).
REQ-002 SHALL have localparam POS_W = $clog2(WIDTH), the width of the decision-position output.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operand pair offered.
REQ-006 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-007 SHALL have port a, input, WIDTH, unsigned operand A.
REQ-008 SHALL have port b, input, WIDTH, unsigned operand B.
REQ-009 SHALL have port out_valid, output, 1, result held on gto/lto/eqo/pos.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port gto, output, 1, A > B.
REQ-012 SHALL have port lto, output, 1, A < B.
REQ-013 SHALL have port eqo, output, 1, A == B.
REQ-014 SHALL have port pos, output, POS_W, bit index where the decision was made; 0 when equal.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DONE; in_ready = 1 only in IDLE with rst low.
REQ-016 SHALL, in IDLE on in_valid & in_ready, register a and b, set idx = WIDTH-1, and go to SCAN; a/b are ignored at all other times.
REQ-017 SHALL, in each SCAN cycle, compare a_q[idx] with b_q[idx], MSB first, one bit pair per cycle.
REQ-018 SHALL, on a_q[idx]=1 and b_q[idx]=0, register gto=1, lto=0, eqo=0, pos=idx and go to DONE.
REQ-019 SHALL, on a_q[idx]=0 and b_q[idx]=1, register lto=1, gto=0, eqo=0, pos=idx and go to DONE.
REQ-020 SHALL, on equal bits with idx=0, register eqo=1, gto=0, lto=0, pos=0 and go to DONE; with idx>0, decrement idx and stay in SCAN.
REQ-021 SHALL terminate early: n = WIDTH-p SCAN cycles, where p is the highest differing bit; n = WIDTH when the operands are equal.
REQ-022 SHALL assert out_valid in DONE only, starting n clock edges after the accepting edge.
REQ-023 SHALL hold gto/lto/eqo/pos stable while out_valid=1 and out_ready=0.
REQ-024 SHALL leave DONE for IDLE on out_valid & out_ready; out_valid deasserts and in_ready asserts the next cycle (no same-cycle accept).
REQ-025 SHALL keep exactly one of gto/lto/eqo high whenever out_valid=1.
REQ-026 SHALL keep gto/lto/eqo/pos unchanged outside DONE, holding the last result until the next decision.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, go to IDLE with out_valid=0, gto=0, lto=0, eqo=0, pos=0, idx=WIDTH-1.
REQ-028 SHALL drive in_ready=0 during any cycle with rst=1.
REQ-029 SHALL abort an in-progress SCAN or undelivered DONE on reset with no result emitted.

Verification
REQ-030 SHALL cover: a=6'b100000, b=6'b011111 accepted at edge E -> out_valid at E+1, gto=1, pos=5.
REQ-031 SHALL cover: a=6'b000001, b=6'b000011 -> out_valid at E+5, lto=1, pos=1.
REQ-032 SHALL cover: a=b=6'h2A -> out_valid at E+6, eqo=1, pos=0.
REQ-033 SHALL cover: out_ready held low 3 cycles after out_valid -> outputs stable, in_ready=0, a toggling in_valid is ignored; result consumed on the 4th cycle, then in_ready=1.
REQ-034 SHALL cover: rst pulsed 1 cycle at the 3rd SCAN cycle of a=b=6'h15 -> out_valid never asserts, all outputs 0, in_ready=1 the cycle after rst falls.
REQ-035 SHALL cover: back-to-back pairs with in_valid and out_ready tied high -> each result matches an arithmetic >/</== reference model; one idle cycle separates each result from the next accept.

Source files
------------

// File: rtl/serial_mag_compare.sv
// serial_mag_compare
//   Bit-serial unsigned magnitude comparator. An accepted operand pair is
//   scanned MSB first, one bit pair per clock. The scan stops at the first
//   differing bit, or after the LSB when the operands are equal. The result
//   is held with a valid/ready handshake until the consumer takes it.
//
// Ports
//   clk       : clock; all state changes on its rising edge
//   rst       : synchronous active-high reset
//   in_valid  : operand pair offered on a/b
//   in_ready  : block is idle and can accept a pair (forced low during rst)
//   a, b      : unsigned operands, WIDTH bits
//   out_valid : result presented on gto/lto/eqo/pos
//   out_ready : consumer accepts the result
//   gto/lto/eqo : A > B, A < B, A == B (exactly one is high while out_valid)
//   pos       : bit index where the decision was made; 0 when equal
module serial_mag_compare #(
  parameter int WIDTH = 6,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gto,
  output logic             lto,
  output logic             eqo,
  output logic [POS_W-1:0] pos
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [POS_W-1:0] idx_q;
  logic             gto_q, lto_q, eqo_q;
  logic [POS_W-1:0] pos_q;

  logic bit_a, bit_b;
  logic accept, decide;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  assign bit_a = a_q[idx_q];
  assign bit_b = b_q[idx_q];

  // A scan cycle ends the scan when the bits differ or the LSB was reached.
  assign decide = (state_q == SCAN) && ((bit_a != bit_b) || (idx_q == '0));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = SCAN;
      SCAN:    if (decide)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Operand capture: data only, loaded on an accepted handshake.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Scan index and result registers; results persist until the next decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= POS_W'(WIDTH - 1);
      gto_q <= 1'b0;
      lto_q <= 1'b0;
      eqo_q <= 1'b0;
      pos_q <= '0;
    end else begin
      if (accept) begin
        idx_q <= POS_W'(WIDTH - 1);
      end else if ((state_q == SCAN) && !decide) begin
        idx_q <= idx_q - POS_W'(1);
      end
      if (decide) begin
        gto_q <= bit_a & ~bit_b;
        lto_q <= ~bit_a & bit_b;
        eqo_q <= (bit_a == bit_b);
        pos_q <= idx_q;
      end
    end
  end

  assign gto = gto_q;
  assign lto = lto_q;
  assign eqo = eqo_q;
  assign pos = pos_q;

endmodule

// File: tb/tb_serial_mag_compare.sv
// tb_serial_mag_compare
//   Directed bench for serial_mag_compare (WIDTH=6): table of operand pairs
//   with hand-computed result and latency, plus sequences for reset, output
//   stall, reset abort and back-to-back operation.
module tb_serial_mag_compare;

  localparam int W     = 6;
  localparam int POS_W = $clog2(W);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a, b;
  logic             out_valid;
  logic             out_ready;
  logic             gto, lto, eqo;
  logic [POS_W-1:0] pos;

  serial_mag_compare #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .gto(gto), .lto(lto), .eqo(eqo), .pos(pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             gt;
    logic             lt;
    logic             eq;
    logic [POS_W-1:0] pos;
    int               lat;
  } vec_t;

  vec_t vecs[10];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Offer a pair at the next negedge; returns after the accepting edge (+1).
  task automatic offer(input logic [W-1:0] va, input logic [W-1:0] vb, input string name);
    @(negedge clk);
    a = va;
    b = vb;
    in_valid = 1'b1;
    #1 check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Count edges after the accept until out_valid, bounded.
  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_ov_after"}, {31'd0, out_valid}, 32'd0);
    check({name, "_ir_after"}, {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input logic egt, input logic elt,
                              input logic eeq, input logic [POS_W-1:0] epos);
    check({name, "_gto"}, {31'd0, gto}, {31'd0, egt});
    check({name, "_lto"}, {31'd0, lto}, {31'd0, elt});
    check({name, "_eqo"}, {31'd0, eqo}, {31'd0, eeq});
    check({name, "_pos"}, {29'd0, pos}, {29'd0, epos});
    check({name, "_onehot"}, 32'(gto) + 32'(lto) + 32'(eqo), 32'd1);
  endtask

  initial begin
    int lat;
    bit ok;
    logic [W-1:0] ea, eb, x;
    logic [POS_W-1:0] epos;
    int elat;
    logic sgt, slt, seq;
    logic [POS_W-1:0] spos;

    //            a          b          gt    lt    eq    pos    lat
    vecs[0] = '{6'b100000, 6'b011111, 1'b1, 1'b0, 1'b0, 3'd5, 1};
    vecs[1] = '{6'b000001, 6'b000011, 1'b0, 1'b1, 1'b0, 3'd1, 5};
    vecs[2] = '{6'h2A,     6'h2A,     1'b0, 1'b0, 1'b1, 3'd0, 6};
    vecs[3] = '{6'b000001, 6'b000000, 1'b1, 1'b0, 1'b0, 3'd0, 6};
    vecs[4] = '{6'h3F,     6'h3E,     1'b1, 1'b0, 1'b0, 3'd0, 6};
    vecs[5] = '{6'h00,     6'h00,     1'b0, 1'b0, 1'b1, 3'd0, 6};
    vecs[6] = '{6'h3F,     6'h3F,     1'b0, 1'b0, 1'b1, 3'd0, 6};
    vecs[7] = '{6'b010000, 6'b011000, 1'b0, 1'b1, 1'b0, 3'd3, 3};
    vecs[8] = '{6'b001000, 6'b000111, 1'b1, 1'b0, 1'b0, 3'd3, 3};
    vecs[9] = '{6'b100000, 6'b110000, 1'b0, 1'b1, 1'b0, 3'd4, 2};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_results", {28'd0, gto, lto, eqo, 1'b0} | {29'd0, pos}, 32'd0);
    rst = 1'b0;
    #1 check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      offer(vecs[i].a, vecs[i].b, $sformatf("v%0d", i));
      in_valid = 1'b0;
      a = ~vecs[i].a;
      b = ~vecs[i].b;
      wait_out(lat, ok);
      check($sformatf("v%0d_timeout", i), {31'd0, ok}, 32'd1);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check_result($sformatf("v%0d", i), vecs[i].gt, vecs[i].lt, vecs[i].eq, vecs[i].pos);
      consume($sformatf("v%0d", i));
    end

    // Output stall: result held 3 cycles, in_valid toggling ignored
    offer(6'h3F, 6'h10, "stall");
    in_valid = 1'b0;
    wait_out(lat, ok);
    check("stall_timeout", {31'd0, ok}, 32'd1);
    check("stall_latency", 32'(lat), 32'd1);
    check_result("stall", 1'b1, 1'b0, 1'b0, 3'd5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = 6'h00;
      b = 6'h3F;
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_ov", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("stall%0d_ir", c), {31'd0, in_ready}, 32'd0);
      check_result($sformatf("stall%0d", c), 1'b1, 1'b0, 1'b0, 3'd5);
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume("stall");
    check_result("stall_hold_idle", 1'b1, 1'b0, 1'b0, 3'd5);

    // Reset abort at the 3rd scan cycle of an equal pair
    offer(6'h15, 6'h15, "abort");
    in_valid = 1'b0;
    @(posedge clk);
    #1 check("abort_scan1_ov", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1 check("abort_scan2_ov", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("abort_rst_ir", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ir", {31'd0, in_ready}, 32'd1);
    check("abort_results", {28'd0, gto, lto, eqo, 1'b0} | {29'd0, pos}, 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1 check($sformatf("abort_quiet%0d", c), {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back with in_valid and out_ready tied high
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      ea = 6'($urandom_range(0, 63));
      eb = (k % 4 == 0) ? ea : 6'($urandom_range(0, 63));
      // Reference: arithmetic compare, highest differing bit by search
      x = ea ^ eb;
      epos = '0;
      for (int j = 0; j < W; j++) if (x[j]) epos = POS_W'(j);
      elat = (x == '0) ? W : (W - int'(epos));
      sgt = (ea > eb);
      slt = (ea < eb);
      seq = (ea == eb);
      spos = epos;
      offer(ea, eb, $sformatf("b2b%0d", k));
      a = 6'($urandom_range(0, 63));
      b = 6'($urandom_range(0, 63));
      wait_out(lat, ok);
      check($sformatf("b2b%0d_timeout", k), {31'd0, ok}, 32'd1);
      check($sformatf("b2b%0d_latency", k), 32'(lat), 32'(elat));
      check_result($sformatf("b2b%0d", k), sgt, slt, seq, spos);
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d_idle_ov", k), {31'd0, out_valid}, 32'd0);
      check($sformatf("b2b%0d_idle_ir", k), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
